// File: rtl/icache_if.sv
// Memory-side refill bus of the instruction cache: a line request/acknowledge
// handshake carrying a line-aligned address out and a 128-bit line back.
interface icache_if;
   logic         mem_req_o;
   logic [31:0]  mem_addr_o;
   logic         mem_ack_i;
   logic [127:0] mem_data_i;

   modport master (
      output mem_req_o,
      output mem_addr_o,
      input  mem_ack_i,
      input  mem_data_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_addr_o,
      output mem_ack_i,
      output mem_data_i
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with 16-byte lines, a same-cycle
// hit path, a stalling refill sequencer and whole-cache invalidation.
module icache #(
   parameter int LINES = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [31:0] pc_i,
   input  logic        invalidate_i,
   output logic [31:0] instr_o,
   output logic        stall_o,
   icache_if.master    mem
);
   localparam int IW = $clog2(LINES);
   localparam int TW = 28 - IW;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_FILL
   } state_e;

   state_e         state_q, state_d;
   logic [31:0]    miss_addr_q, miss_addr_d;
   logic [127:0]   fill_buf_q, fill_buf_d;
   logic           inval_pend_q, inval_pend_d;

   logic           valid_q [LINES];
   logic [TW-1:0]  tag_q   [LINES];
   logic [127:0]   data_q  [LINES];

   logic [IW-1:0]  look_idx;
   logic [TW-1:0]  look_tag;
   logic [1:0]     look_off;
   logic [127:0]   look_line;
   logic [31:0]    look_word;
   logic           hit;

   logic [IW-1:0]  fill_idx;
   logic [TW-1:0]  fill_tag;
   logic           fill_we;
   logic           clear_all;

   logic           unused_pc_bits;
   assign unused_pc_bits = ^pc_i[1:0];

   assign look_idx  = pc_i[IW+3:4];
   assign look_tag  = pc_i[31:IW+4];
   assign look_off  = pc_i[3:2];
   assign look_line = data_q[look_idx];

   assign fill_idx  = miss_addr_q[IW+3:4];
   assign fill_tag  = miss_addr_q[31:IW+4];

   always_comb begin
      look_word = look_line[31:0];
      case (look_off)
         2'd0: look_word = look_line[31:0];
         2'd1: look_word = look_line[63:32];
         2'd2: look_word = look_line[95:64];
         2'd3: look_word = look_line[127:96];
         default: look_word = look_line[31:0];
      endcase
   end

   // A pending invalidate makes the whole cache look empty for the cycle that applies it.
   assign hit = (state_q == S_IDLE) && !inval_pend_q &&
                valid_q[look_idx] && (tag_q[look_idx] == look_tag);

   always_comb begin
      state_d      = state_q;
      miss_addr_d  = miss_addr_q;
      fill_buf_d   = fill_buf_q;
      inval_pend_d = inval_pend_q;
      clear_all    = 1'b0;
      fill_we      = 1'b0;
      stall_o      = 1'b0;
      instr_o      = NOP;
      mem.mem_req_o  = 1'b0;
      mem.mem_addr_o = 32'h0;

      case (state_q)
         S_IDLE: begin
            if (inval_pend_q || invalidate_i) begin
               clear_all = 1'b1;
            end
            inval_pend_d = 1'b0;
            if (req_i) begin
               if (hit) begin
                  instr_o = look_word;
               end else begin
                  stall_o     = 1'b1;
                  miss_addr_d = {pc_i[31:4], 4'b0000};
                  state_d     = S_REQ;
               end
            end
         end

         S_REQ: begin
            stall_o        = 1'b1;
            mem.mem_req_o  = 1'b1;
            mem.mem_addr_o = miss_addr_q;
            if (invalidate_i) begin
               inval_pend_d = 1'b1;
            end
            if (mem.mem_ack_i) begin
               fill_buf_d = mem.mem_data_i;
               state_d    = S_FILL;
            end
         end

         S_FILL: begin
            stall_o = 1'b1;
            fill_we = 1'b1;
            if (invalidate_i) begin
               inval_pend_d = 1'b1;
            end
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         miss_addr_q  <= 32'h0;
         inval_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         miss_addr_q  <= miss_addr_d;
         inval_pend_q <= inval_pend_d;
      end
   end

   always_ff @(posedge clk_i) begin
      fill_buf_q <= fill_buf_d;
   end

   // Tag and data carry no reset: the valid bit alone decides whether they mean anything.
   always_ff @(posedge clk_i) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= fill_buf_q;
      end
   end

   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk_i) begin
            if (rst_i || clear_all) begin
               valid_q[gi] <= 1'b0;
            end else if (fill_we && (fill_idx == IW'(gi))) begin
               valid_q[gi] <= 1'b1;
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: stimulus pushes expected words and refill requests
// into queues, and a monitor compares them as the cache delivers or requests.
module tb_icache;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic [31:0] pc_i;
   logic        invalidate_i;
   logic [31:0] instr_o;
   logic        stall_o;

   icache_if mem_bus ();

   icache #(.LINES(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .pc_i         (pc_i),
      .invalidate_i (invalidate_i),
      .instr_o      (instr_o),
      .stall_o      (stall_o),
      .mem          (mem_bus.master)
   );

   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_instr_q [$];
   logic [31:0] exp_addr_q  [$];
   int          exp_len_q   [$];

   int ack_wait = 0;
   bit hold_ack = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory contents: line 0x1000 holds 1..4, every other word holds its own address.
   function automatic logic [31:0] model_word(input logic [31:0] pc);
      logic [31:0] w;
      if (pc[31:4] == 28'h0000100) w = {30'd0, pc[3:2]} + 32'd1;
      else                         w = {pc[31:2], 2'b00};
      return w;
   endfunction

   function automatic logic [127:0] line_of(input logic [31:0] addr);
      logic [31:0] base;
      base = {addr[31:4], 4'b0000};
      return {model_word(base + 32'd12), model_word(base + 32'd8),
              model_word(base + 32'd4), model_word(base)};
   endfunction

   // Memory responder: acks the w-th REQ cycle (0 = first) with the line data.
   initial begin
      int req_cycles;
      req_cycles = 0;
      mem_bus.mem_ack_i  = 1'b0;
      mem_bus.mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         if (mem_bus.mem_req_o && !rst_i) begin
            if (req_cycles >= ack_wait) begin
               mem_bus.mem_ack_i  = 1'b1;
               mem_bus.mem_data_i = line_of(mem_bus.mem_addr_o);
            end else begin
               mem_bus.mem_ack_i  = hold_ack;
            end
            req_cycles++;
         end else begin
            mem_bus.mem_ack_i = hold_ack && !rst_i;
            req_cycles = 0;
         end
      end
   end

   // Monitor: compares deliveries and refill requests against the queues.
   initial begin
      logic prev_req;
      int   hi_cnt;
      prev_req = 1'b0;
      hi_cnt   = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_i && req_i && !stall_o) begin
            if (exp_instr_q.size() == 0) begin
               check("unexpected_delivery", pc_i, 32'hFFFF_FFFF);
            end else begin
               check($sformatf("instr@%h", pc_i), instr_o, exp_instr_q.pop_front());
            end
         end
         if (stall_o) check("instr_nop_in_stall", instr_o, NOP);
         if (mem_bus.mem_req_o && !prev_req) begin
            if (exp_addr_q.size() == 0) begin
               check("unexpected_mem_req", mem_bus.mem_addr_o, 32'hFFFF_FFFF);
            end else begin
               check("mem_addr", mem_bus.mem_addr_o, exp_addr_q.pop_front());
            end
         end
         if (!mem_bus.mem_req_o && mem_bus.mem_addr_o != 32'h0) begin
            check("mem_addr_idle_zero", mem_bus.mem_addr_o, 32'h0);
         end
         if (mem_bus.mem_req_o) begin
            hi_cnt++;
         end else if (prev_req) begin
            if (exp_len_q.size() == 0) check("unexpected_req_len", hi_cnt, 32'hFFFF_FFFF);
            else                       check("mem_req_len", hi_cnt, exp_len_q.pop_front());
            hi_cnt = 0;
         end
         prev_req = mem_bus.mem_req_o;
      end
   end

   // One fetch until delivery; inval_cyc pulses invalidate_i in that cycle of the fetch.
   task automatic fetch(input logic [31:0] pc, input int nmiss, input int w, input int inval_cyc);
      int  cyc;
      int  stalls;
      bit  done;
      cyc    = 0;
      stalls = 0;
      done   = 1'b0;
      req_i    = 1'b1;
      pc_i     = pc;
      ack_wait = w;
      for (int k = 0; k < nmiss; k++) begin
         exp_addr_q.push_back({pc[31:4], 4'b0000});
         exp_len_q.push_back(w + 1);
      end
      exp_instr_q.push_back(model_word(pc));
      while (!done) begin
         invalidate_i = (cyc == inval_cyc);
         @(negedge clk_i);
         if (!stall_o) done = 1'b1;
         else          stalls++;
         if (!done && cyc > 200) begin
            check("fetch_timeout", pc, 32'hFFFF_FFFF);
            done = 1'b1;
         end
         @(posedge clk_i); #1;
         cyc++;
      end
      invalidate_i = 1'b0;
      check($sformatf("stall_cycles@%h", pc), stalls, nmiss * (w + 3));
   endtask

   initial begin
      rst_i        = 1'b1;
      req_i        = 1'b1;
      pc_i         = 32'h1000;
      invalidate_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check("rst_stall", {31'd0, stall_o}, 32'd1);
      check("rst_instr", instr_o, NOP);
      check("rst_mem_req", {31'd0, mem_bus.mem_req_o}, 32'd0);
      check("rst_mem_addr", mem_bus.mem_addr_o, 32'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // Cold miss, then spatial hits on the same line.
      fetch(32'h1000, 1, 3, -1);
      fetch(32'h1004, 0, 0, -1);
      fetch(32'h1008, 0, 0, -1);
      fetch(32'h100C, 0, 0, -1);

      // Conflict eviction on index 0 and re-miss of the evicted line.
      fetch(32'h1040, 1, 1, -1);
      fetch(32'h1000, 1, 2, -1);

      // Zero-wait ack with ack held high, including outside REQ.
      hold_ack = 1'b1;
      fetch(32'h3008, 1, 0, -1);
      fetch(32'h300C, 0, 0, -1);
      hold_ack = 1'b0;

      // Invalidate during the second REQ cycle: fill completes, then re-miss.
      fetch(32'h2000, 2, 3, 2);

      // Invalidate in IDLE: same-cycle lookup hits, next lookup misses.
      fetch(32'h2004, 0, 0, 0);
      fetch(32'h2004, 1, 1, -1);

      // Reset in the second REQ cycle abandons the refill.
      fetch(32'h1010, 1, 0, -1);
      ack_wait = 10;
      req_i    = 1'b1;
      pc_i     = 32'h5020;
      exp_addr_q.push_back(32'h5020);
      exp_len_q.push_back(2);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      req_i = 1'b0;
      @(negedge clk_i);
      check("req_before_rst_edge", {31'd0, mem_bus.mem_req_o}, 32'd1);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("req_after_rst", {31'd0, mem_bus.mem_req_o}, 32'd0);
      check("stall_after_rst", {31'd0, stall_o}, 32'd0);
      @(posedge clk_i); #1;
      fetch(32'h1010, 1, 0, -1);

      req_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("instr_queue_drained", exp_instr_q.size(), 32'd0);
      check("addr_queue_drained", exp_addr_q.size(), 32'd0);
      check("len_queue_drained", exp_len_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the fetch stage and the instruction memory port. Fetch presents its current PC each cycle. On a hit the instruction is returned combinationally in the same cycle. On a miss the cache stalls the core, refills the 128-bit line over a request/acknowledge memory handshake, and then returns the instruction. It also handles whole-cache invalidation for instruction-stream writes (fence.i).

## Interface
- LINES, 4, number of cache lines; power of two, ≥2.
- Line size is fixed: 16 bytes (4 words), not parameterised.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  fetch wants an instruction at pc_i this cycle.
- pc_i  in  32  fetch PC; bits [1:0] ignored.
- invalidate_i  in  1  one-cycle pulse: clear all valid bits.
- instr_o  out  32  instruction at pc_i on hit; 32'h00000013 (NOP) otherwise.
- stall_o  out  1  core must hold PC and pipeline this cycle.
- mem_req_o  out  1  line refill request.
- mem_addr_o  out  32  line-aligned refill address, bits [3:0] = 0.
- mem_ack_i  in  1  refill data valid this cycle.
- mem_data_i  in  128  refill line; word k at bits [32k+31:32k].

## Operation
- Address split, with IW = log2(LINES):
  - offset = pc_i[3:2]
  - index = pc_i[IW+3:4]
  - tag = pc_i[31:IW+4]
- Storage per line: valid bit, tag, 128-bit data.
- Hit condition: valid[index] and tag[index] equal to the pc_i tag.
- States:
  - IDLE: lookup active.
    - Hit: instr_o = selected word, stall_o = 0.
    - req_i & !hit: stall_o = 1; latch miss_addr = {pc_i[31:4], 4'b0}; go to REQ.
    - req_i = 0: stall_o = 0, no state change.
  - REQ: mem_req_o = 1, mem_addr_o = miss_addr, stall_o = 1.
    - Hold until mem_ack_i = 1.
    - On the ack edge, capture mem_data_i into the fill buffer; go to FILL.
  - FILL: stall_o = 1, mem_req_o = 0.
    - On the edge, write the fill buffer, the tag of miss_addr, and valid = 1 into line index(miss_addr); go to IDLE.
- Outside IDLE: instr_o = NOP, and hit is not reported.
- mem_addr_o = 0 whenever mem_req_o = 0.
- invalidate_i:
  - In IDLE: clear all valid bits on the edge. A lookup in that same cycle still uses the old valid bits.
  - In REQ or FILL: set inval_pend. After the FILL write, in the first IDLE cycle, clear all valid bits (including the line just filled) and clear inval_pend. That IDLE cycle reports miss, so fetch re-misses.
- The PC is not latched for returning data. After FILL, the lookup uses the current pc_i; fetch holds pc_i while stall_o = 1.
- Conflict miss: the refill overwrites the resident line unconditionally. No write-back is needed (read-only cache).

## Timing
- Reset (rst_i sampled high on an edge), effective that same edge:
  - state = IDLE
  - all valid bits = 0
  - inval_pend = 0
  - miss_addr = 0
  - mem_req_o = 0, mem_addr_o = 0
  - stall_o = req_i (everything misses), instr_o = NOP
- Reset during REQ: mem_req_o drops the next cycle with no ack required. Memory discards the abandoned request.
- Hit latency: 0 cycles (combinational from pc_i).
- Miss penalty with ack arriving W cycles after mem_req_o rises (W ≥ 0; W = 0 means ack in the first REQ cycle):
  - cycle 0: IDLE miss
  - cycles 1..W+1: REQ
  - cycle W+2: FILL
  - cycle W+3: IDLE hit, stall_o = 0
- mem_req_o is high for exactly W+1 cycles per miss and never drops before ack.
- mem_ack_i outside REQ is ignored.
- Arrays are written only in FILL and on invalidate/reset. A simultaneous FILL write and pending invalidate cannot occur, because the deferred invalidate applies in the following IDLE cycle.

## Test plan
- Cold miss: reset; req_i = 1, pc_i = 0x1000.
  - Required: stall_o = 1; mem_req_o rises the next cycle with mem_addr_o = 0x1000.
  - Ack after 3 cycles with mem_data_i = {0x4,0x3,0x2,0x1} (word 3 … word 0).
  - Required: instr_o = 0x1, stall_o = 0 at cycle 6.
- Spatial hit: immediately after the cold miss, pc_i = 0x1004, 0x1008, 0x100C.
  - Required: instr_o = 0x2, 0x3, 0x4 with stall_o = 0 every cycle and no mem_req_o.
- Conflict eviction: with 0x1000 resident (LINES = 4), pc_i = 0x1040.
  - Required: miss, mem_addr_o = 0x1040, refill.
  - Then pc_i = 0x1000 misses again with mem_addr_o = 0x1000.
- Zero-wait ack: mem_ack_i held high.
  - Required: mem_req_o high exactly 1 cycle; 3-cycle stall; correct word returned.
- Deferred invalidate: pulse invalidate_i during REQ for 0x2000.
  - Required: the fill completes; the first IDLE cycle misses; 0x2000 is requested again.
  - Invalidate in IDLE: the next cycle's lookup of a previously resident PC misses.
- Reset mid-refill: assert rst_i in the second REQ cycle.
  - Required: mem_req_o = 0 the next cycle, state IDLE, and a prior resident PC misses.
